// File: rtl/controle_velocidade.sv
// controle_velocidade: debounced accelerate/brake buttons set a 0..2 target; the applied
// level ramps toward it one step per RAMP_CYCLES and drives a registered PWM motor output.
module controle_velocidade #(
    parameter int DEB_CYCLES  = 16,
    parameter int RAMP_CYCLES = 8,
    parameter int PWM_STEP    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_acel_n,
    input  logic       btn_frear_n,
    input  logic       parar,
    output logic [1:0] vel_atual,
    output logic [1:0] vel_alvo,
    output logic       em_rampa,
    output logic       vel_chave1,
    output logic       vel_chave2,
    output logic       pwm_motor
);
    localparam int DW = $clog2(DEB_CYCLES);
    localparam int RW = RAMP_CYCLES > 1 ? $clog2(RAMP_CYCLES) : 1;
    localparam int PW = $clog2(2 * PWM_STEP);

    typedef enum logic [1:0] {PARADO, SOBE, DESCE, ESTAVEL} estado_t;

    estado_t       estado, estado_nxt;
    logic [1:0]    btn_s1, btn_s2, smp, flip, deb, armado, pulso;
    logic          par_s1, par_s2;
    logic [DW-1:0] deb_cnt [2];
    logic [RW-1:0] cnt_rampa, cnt_rampa_nxt;
    logic [PW-1:0] cnt_pwm;
    logic [PW:0]   duty;
    logic [1:0]    atual_nxt, alvo_nxt;
    logic          acel, frear, rampa, passo;

    // Button synchronizers reset to "pressed": a button held across reset never arms, so no pulse follows
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            par_s1 <= 1'b0;
            par_s2 <= 1'b0;
        end else begin
            btn_s1 <= {btn_frear_n, btn_acel_n};
            btn_s2 <= btn_s1;
            par_s1 <= parar;
            par_s2 <= par_s1;
        end

    assign smp = ~btn_s2;

    always_comb begin
        flip = '0;
        for (int i = 0; i < 2; i++)
            flip[i] = smp[i] != deb[i] && deb_cnt[i] == DW'(DEB_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            deb    <= '0;
            armado <= '0;
            pulso  <= '0;
            for (int i = 0; i < 2; i++)
                deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++)
                deb_cnt[i] <= (smp[i] == deb[i] || flip[i]) ? '0 : deb_cnt[i] + 1'b1;
            deb    <= deb ^ flip;
            pulso  <= flip & smp & armado;
            armado <= armado | ~smp;
        end

    always_comb begin
        acel          = pulso[0] & ~pulso[1];
        frear         = pulso[1] & ~pulso[0];
        alvo_nxt      = par_s2 ? 2'd0
                      : acel   ? (vel_alvo == 2'd2 ? 2'd2 : vel_alvo + 2'd1)
                      : frear  ? (vel_alvo == 2'd0 ? 2'd0 : vel_alvo - 2'd1)
                      : vel_alvo;
        rampa         = estado == SOBE || estado == DESCE;
        passo         = rampa && cnt_rampa == RW'(RAMP_CYCLES - 1);
        atual_nxt     = par_s2 ? 2'd0
                      : !passo ? vel_atual
                      : estado == SOBE ? vel_atual + 2'd1 : vel_atual - 2'd1;
        estado_nxt    = atual_nxt == alvo_nxt ? (atual_nxt == 2'd0 ? PARADO : ESTAVEL)
                      : atual_nxt < alvo_nxt ? SOBE : DESCE;
        cnt_rampa_nxt = (rampa && !passo && (estado_nxt == SOBE || estado_nxt == DESCE))
                      ? cnt_rampa + 1'b1 : '0;
        duty          = (PW+1)'(vel_atual) * (PW+1)'(PWM_STEP);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            estado    <= PARADO;
            vel_atual <= 2'd0;
            vel_alvo  <= 2'd0;
            cnt_rampa <= '0;
            cnt_pwm   <= '0;
            pwm_motor <= 1'b0;
        end else begin
            estado    <= estado_nxt;
            vel_atual <= atual_nxt;
            vel_alvo  <= alvo_nxt;
            cnt_rampa <= cnt_rampa_nxt;
            cnt_pwm   <= cnt_pwm == PW'(2 * PWM_STEP - 1) ? '0 : cnt_pwm + 1'b1;
            pwm_motor <= {1'b0, cnt_pwm} < duty;
        end

    assign em_rampa   = vel_atual != vel_alvo;
    assign vel_chave1 = vel_atual == 2'd2;
    assign vel_chave2 = vel_atual == 2'd1;
endmodule

// File: tb/tb_controle_velocidade.sv
// tb_controle_velocidade: directed button/stop/reset scenarios, checked every cycle against
// an arithmetic model of the speed controller plus hand-computed timing expectations.
module tb_controle_velocidade;
    localparam int DEB = 4, RAMP = 3, STEP = 2;

    logic       clk = 1'b0, rst_n = 1'b0, btn_acel_n = 1'b1, btn_frear_n = 1'b1, parar = 1'b0;
    logic [1:0] vel_atual, vel_alvo;
    logic       em_rampa, vel_chave1, vel_chave2, pwm_motor;
    int         tests = 0, fails = 0;

    controle_velocidade #(.DEB_CYCLES(DEB), .RAMP_CYCLES(RAMP), .PWM_STEP(STEP)) dut (
        .clk(clk), .rst_n(rst_n), .btn_acel_n(btn_acel_n), .btn_frear_n(btn_frear_n),
        .parar(parar), .vel_atual(vel_atual), .vel_alvo(vel_alvo), .em_rampa(em_rampa),
        .vel_chave1(vel_chave1), .vel_chave2(vel_chave2), .pwm_motor(pwm_motor)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: pin delay lines, debounce run lengths, target, applied level, ramp timer, edge count
    int dly [2][2];
    int dp [2];
    int lvl [2], run [2], arm [2], pul [2];
    int m_atual, m_alvo, m_t, m_n, m_pwm;

    task automatic mreset();
        for (int b = 0; b < 2; b++) begin
            dly[b][0] = 0; dly[b][1] = 0;
            lvl[b] = 0; run[b] = 0; arm[b] = 0; pul[b] = 0;
        end
        dp[0] = 0; dp[1] = 0;
        m_atual = 0; m_alvo = 0; m_t = 0; m_n = 0; m_pwm = 0;
    endtask

    task automatic mstep();
        int pin [2];
        int pa, pf, stop, smp, ramp, step, an, aln;
        pin[0] = btn_acel_n;
        pin[1] = btn_frear_n;
        pa = pul[0];
        pf = pul[1];
        stop = dp[1];
        dp[1] = dp[0];
        dp[0] = parar;
        for (int b = 0; b < 2; b++) begin
            smp = dly[b][1] == 0 ? 1 : 0;
            dly[b][1] = dly[b][0];
            dly[b][0] = pin[b];
            pul[b] = 0;
            if (smp == lvl[b]) run[b] = 0;
            else begin
                run[b]++;
                if (run[b] == DEB) begin
                    lvl[b] = smp;
                    run[b] = 0;
                    pul[b] = smp & arm[b];
                end
            end
            if (smp == 0) arm[b] = 1;
        end
        m_pwm = (m_n % (2 * STEP)) < m_atual * STEP ? 1 : 0;
        m_n++;
        aln = m_alvo;
        if (pa && !pf && m_alvo < 2) aln = m_alvo + 1;
        if (pf && !pa && m_alvo > 0) aln = m_alvo - 1;
        if (stop) aln = 0;
        ramp = m_atual != m_alvo;
        step = ramp && m_t == RAMP - 1;
        an = step ? m_atual + (m_alvo > m_atual ? 1 : -1) : m_atual;
        if (stop) an = 0;
        m_t = (ramp && !step && an != aln) ? m_t + 1 : 0;
        m_atual = an;
        m_alvo = aln;
    endtask

    initial begin
        mreset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) mreset();
            else mstep();
        end
    end

    initial forever begin
        @(posedge clk);
        #2;
        chk("cyc_atual", vel_atual, m_atual);
        chk("cyc_alvo", vel_alvo, m_alvo);
        chk("cyc_rampa", em_rampa, m_atual != m_alvo);
        chk("cyc_chave1", vel_chave1, m_atual == 2);
        chk("cyc_chave2", vel_chave2, m_atual == 1);
        chk("cyc_pwm", pwm_motor, m_pwm);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_highs(output int hi);
        hi = 0;
        repeat (2 * STEP) begin
            cyc(1);
            hi += pwm_motor;
        end
    endtask

    int hi;

    initial begin
        cyc(3);
        chk("rst_atual", vel_atual, 0);
        chk("rst_alvo", vel_alvo, 0);
        chk("rst_rampa", em_rampa, 0);
        chk("rst_pwm", pwm_motor, 0);
        chk("rst_chave1", vel_chave1, 0);
        chk("rst_chave2", vel_chave2, 0);
        rst_n = 1'b1;
        cyc(5);
        // First accelerate: target after 2+DEB+1 edges, applied level RAMP edges later
        btn_acel_n = 1'b0;
        cyc(6);
        chk("alvo_pre_pulse", vel_alvo, 0);
        cyc(1);
        chk("alvo_7_edges", vel_alvo, 1);
        chk("rampa_on", em_rampa, 1);
        cyc(2);
        chk("atual_pre_step", vel_atual, 0);
        cyc(1);
        chk("atual_step1", vel_atual, 1);
        chk("chave2_lvl1", vel_chave2, 1);
        chk("chave1_lvl1", vel_chave1, 0);
        btn_acel_n = 1'b1;
        cyc(1);
        pwm_highs(hi);
        chk("pwm_half", hi, STEP);
        repeat (4) begin
            btn_acel_n = 1'b0;
            cyc(8);
            btn_acel_n = 1'b1;
            cyc(8);
        end
        cyc(10);
        chk("sat_alvo", vel_alvo, 2);
        chk("sat_atual", vel_atual, 2);
        chk("sat_chave1", vel_chave1, 1);
        chk("sat_rampa", em_rampa, 0);
        pwm_highs(hi);
        chk("pwm_full", hi, 2 * STEP);
        btn_frear_n = 1'b0;
        cyc(3);
        btn_frear_n = 1'b1;
        cyc(10);
        chk("glitch_alvo", vel_alvo, 2);
        btn_acel_n = 1'b0;
        btn_frear_n = 1'b0;
        cyc(8);
        btn_acel_n = 1'b1;
        btn_frear_n = 1'b1;
        cyc(10);
        chk("both_alvo", vel_alvo, 2);
        // Brake 2->1->0, each applied step RAMP edges after its target change
        btn_frear_n = 1'b0;
        cyc(9);
        chk("brake1_alvo", vel_alvo, 1);
        chk("brake1_pre", vel_atual, 2);
        cyc(1);
        chk("brake1_step", vel_atual, 1);
        btn_frear_n = 1'b1;
        cyc(10);
        btn_frear_n = 1'b0;
        cyc(9);
        chk("brake2_pre", vel_atual, 1);
        cyc(1);
        chk("brake2_step", vel_atual, 0);
        chk("brake2_alvo", vel_alvo, 0);
        btn_frear_n = 1'b1;
        cyc(10);
        // Emergency stop in the middle of a 0->2 ramp
        btn_acel_n = 1'b0;
        cyc(8);
        btn_acel_n = 1'b1;
        cyc(6);
        btn_acel_n = 1'b0;
        cyc(7);
        chk("ramp_alvo2", vel_alvo, 2);
        chk("ramp_atual1", vel_atual, 1);
        parar = 1'b1;
        cyc(2);
        chk("parar_sync", vel_atual, 1);
        cyc(1);
        chk("parar_atual", vel_atual, 0);
        chk("parar_alvo", vel_alvo, 0);
        btn_acel_n = 1'b1;
        cyc(8);
        btn_acel_n = 1'b0;
        cyc(8);
        btn_acel_n = 1'b1;
        cyc(8);
        chk("parar_ignore", vel_alvo, 0);
        parar = 1'b0;
        cyc(4);
        btn_acel_n = 1'b0;
        cyc(8);
        chk("after_parar", vel_alvo, 1);
        chk("after_parar_rampa", em_rampa, 1);
        // Asynchronous reset mid-ramp with the button still held
        #2 rst_n = 1'b0;
        #1;
        chk("arst_alvo", vel_alvo, 0);
        chk("arst_atual", vel_atual, 0);
        chk("arst_rampa", em_rampa, 0);
        chk("arst_pwm", pwm_motor, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(20);
        chk("held_reset_alvo", vel_alvo, 0);
        chk("held_reset_atual", vel_atual, 0);
        btn_acel_n = 1'b1;
        cyc(10);
        btn_acel_n = 1'b0;
        cyc(8);
        chk("rearm_alvo", vel_alvo, 1);
        btn_acel_n = 1'b1;
        cyc(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
